// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package stream_demux_pkg;

    localparam int          DROP_CNT_W   = 8;
    localparam logic [7:0]  DROP_CNT_MAX = 8'hFF;

    // Select width never collapses to zero bits, even for a single channel.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Load wins over take so a simultaneous refill keeps the channel streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= {WIDTH{1'b0}};
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (take) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N valid/ready stream demultiplexer with per-channel holding
// slots, illegal-select drop detection and a saturating drop counter.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 2,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   sel_err,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int               SLOTS     = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    logic                  sel_legal_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  drop_s;
    logic [N_OUT-1:0]      load_s;
    logic [N_OUT-1:0]      take_s;
    logic [SLOTS-1:0]      valid_pad_s;
    logic [SLOTS-1:0]      ready_pad_s;
    logic                  sel_err_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    assign sel_legal_s = ({1'b0, in_sel} < N_OUT_EXT);

    // Pad channel status to a power of two so any select value indexes safely.
    always_comb begin
        valid_pad_s = {SLOTS{1'b0}};
        ready_pad_s = {SLOTS{1'b0}};
        valid_pad_s[N_OUT-1:0] = out_valid;
        ready_pad_s[N_OUT-1:0] = out_ready;
    end

    // Ready depends only on the addressed channel; illegal selects always drain.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (sel_legal_s) begin
            in_ready_s = ~valid_pad_s[in_sel] | ready_pad_s[in_sel];
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid & in_ready_s;
    assign drop_s   = accept_s & ~sel_legal_s;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign load_s[k] = accept_s & sel_legal_s & (in_sel == SEL_W'(k));
        assign take_s[k] = out_valid[k] & out_ready[k];

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[k]),
            .take  (take_s[k]),
            .d     (in_data),
            .valid (out_valid[k]),
            .q     (out_data[k*WIDTH +: WIDTH])
        );
    end

    // Error pulse and saturating drop counter for beats with an illegal select.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_r  <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            sel_err_r <= drop_s;
            if (drop_s && (drop_cnt_r != DROP_CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign sel_err  = sel_err_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux (N_OUT=3 so illegal selects are reachable).
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int N_OUT = 3;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [1:0]             in_sel;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   sel_err;
    logic [7:0]             drop_cnt;

    stream_demux #(.WIDTH(WIDTH), .N_OUT(N_OUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-channel queue of beats in flight, last data seen.
    logic [7:0] exp_q [N_OUT][$];
    logic [7:0] last_data [N_OUT];
    int         drop_model = 0;
    bit         err_pending = 1'b0;
    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_sel;
    bit         rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT state to model, then advance the model for the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_rdy;
            logic [7:0] got;
            bit in_xfer;
            for (int k = 0; k < N_OUT; k++) begin
                check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
                check($sformatf("out_data[%0d]", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(last_data[k]));
                check($sformatf("occupancy[%0d]", k), 32'(exp_q[k].size() <= 1), 32'd1);
            end
            check("sel_err", 32'(sel_err), 32'(err_pending));
            check("drop_cnt", 32'(drop_cnt), 32'(drop_model));
            if (rst)                        exp_rdy = 1'b0;
            else if (int'(in_sel) >= N_OUT) exp_rdy = 1'b1;
            else exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (prev_stall) begin
                check("stable_valid", 32'(in_valid), 32'd1);
                check("stable_data", 32'(in_data), 32'(prev_data));
                check("stable_sel", 32'(in_sel), 32'(prev_sel));
            end
            prev_stall = in_valid && !exp_rdy && !rst;
            prev_data  = in_data;
            prev_sel   = in_sel;

            err_pending = 1'b0;
            if (rst) begin
                for (int k = 0; k < N_OUT; k++) begin
                    exp_q[k].delete();
                    last_data[k] = 8'h00;
                end
                drop_model = 0;
            end else begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (exp_q[k].size() != 0 && out_ready[k]) begin
                        got = out_data[k*WIDTH +: WIDTH];
                        check($sformatf("order[%0d]", k), 32'(got), 32'(exp_q[k].pop_front()));
                    end
                end
                in_xfer = in_valid && exp_rdy;
                if (in_xfer) begin
                    if (int'(in_sel) < N_OUT) begin
                        exp_q[in_sel].push_back(in_data);
                        last_data[in_sel] = in_data;
                    end else begin
                        err_pending = 1'b1;
                        if (drop_model < 255) drop_model++;
                    end
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic [1:0] s);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat %0h sel %0d not accepted after %0d cycles", d, s, w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        time t0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 3'b000;
        for (int k = 0; k < N_OUT; k++) last_data[k] = 8'h00;
        @(posedge clk); #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Basic routing
        out_ready = 3'b111;
        send(8'hA5, 2'd0);
        send(8'h3C, 2'd1);
        idle(3);

        // Back-pressure isolation
        out_ready = 3'b110;
        send(8'h11, 2'd0);
        t0 = $time;
        send(8'h33, 2'd1);
        check("other_channel_latency", 32'(($time - t0) / 10), 32'd1);
        fork
            send(8'h22, 2'd0);
            begin idle(4); out_ready = 3'b111; end
        join
        idle(3);

        // Full throughput behind a full channel
        out_ready = 3'b101;
        send(8'h00, 2'd1);
        out_ready = 3'b111;
        t0 = $time;
        for (int i = 1; i <= 8; i++) send(8'(i), 2'd1);
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd8);
        idle(3);

        // Randomised traffic with random back-pressure
        rand_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(8'($urandom), 2'($urandom_range(3, 0)));
                    if ($urandom_range(3, 0) == 0) idle(1);
                end
                rand_rdy = 1'b0;
            end
            begin
                while (rand_rdy) begin
                    @(posedge clk); #1;
                    if (rand_rdy) out_ready = 3'($urandom);
                end
            end
        join
        out_ready = 3'b111;
        idle(4);

        // Reset clears drop count, then illegal selects saturate it
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        send(8'hFF, 2'd3);
        idle(3);
        for (int i = 0; i < 300; i++) send(8'($urandom), 2'd3);
        idle(2);

        // Reset mid-operation with held beats
        out_ready = 3'b000;
        send(8'h5A, 2'd0);
        send(8'h6B, 2'd1);
        idle(1);
        rst = 1'b1; idle(1); rst = 1'b0;
        out_ready = 3'b111;
        idle(5);

        for (int k = 0; k < N_OUT; k++)
            check($sformatf("drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1:N stream demultiplexer with valid/ready handshake.
- It is the distribution-side counterpart of the team's 2:1 selector. One input stream is routed, beat by beat, to the output channel named by in_sel.
- Each channel has its own one-entry holding register, so a stalled channel does not block beats addressed to other channels.
- It sits between a shared producer and N independent consumers.

Parameters:
- WIDTH, 8, data width in bits of every beat.
- N_OUT, 2, number of output channels; legal range 2..16.
- SEL_W, $clog2(N_OUT), localparam (not overridable), width of in_sel.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  demux accepts the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  SEL_W  destination channel index; sampled together with in_data.
- out_valid  output  N_OUT  bit k: channel k holds a beat.
- out_ready  input  N_OUT  bit k: consumer k takes the beat.
- out_data  output  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel_err  output  1  one-cycle pulse: a beat with in_sel >= N_OUT was dropped.
- drop_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, applied on any rising clk edge with rst=1:
  - out_valid = 0, out_data = 0, sel_err = 0, drop_cnt = 0.
  - in_ready = 0 while rst = 1.
- Input transfer happens when in_valid & in_ready.
  - Inputs must be stable while in_valid=1 and in_ready=0 (producer obligation; the bench checks this).
- Output transfer on channel k happens when out_valid[k] & out_ready[k].
- Ready rule for a legal sel:
  - in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
  - This is combinational from in_sel, out_valid and out_ready. There is no path from in_valid.
- Ready rule for an illegal sel (in_sel >= N_OUT, only possible when N_OUT is not a power of 2):
  - in_ready = ~rst.
  - The beat is consumed and discarded.
  - sel_err = 1 on the next cycle only.
  - drop_cnt increments and saturates at 255.
- Latency: an accepted beat appears on out_valid[in_sel] and the matching out_data slice on the cycle after acceptance.
- Per-channel slot, evaluated each cycle:
  - Load (input transfer to k) and output transfer on k together: the slot loads the new data and out_valid[k] stays 1. Full throughput of one beat per cycle per channel.
  - Output transfer only: out_valid[k] clears to 0. out_data keeps its last value (don't-care to consumers).
  - Load only: out_valid[k] is set to 1 and data is loaded.
  - Neither: the slot holds.
- Full channel: out_valid[k]=1 and out_ready[k]=0 gives in_ready=0 for beats addressed to k. A beat addressed to another, non-full channel is accepted in the same cycle.
- Ordering: beat order is preserved within a channel. No ordering is guaranteed across channels.
- At most one input transfer per cycle. Output transfers on different channels are independent and may be simultaneous.
- Reset mid-operation: held beats are discarded, out_valid clears on that edge, and drop_cnt does not count them.

Decomposition:
- Package stream_demux_pkg:
  - DROP_CNT_W = 8.
  - DROP_CNT_MAX = 8'hFF.
  - Function sel_width(n) returning max(1, clog2(n)).
- Sub-module demux_slot: one-entry valid/data holding register.
  - Ports: clk, rst, load, take, d, valid, q.
  - Instantiated N_OUT times via generate.
- Routing, ready logic, error pulse and drop counter live in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_data=0, in_ready=0, drop_cnt=0; after rst=0 -> in_ready=1.
- Basic routing, N_OUT=2, out_ready=2'b11: send data=0xA5 sel=0, then 0x3C sel=1 on consecutive cycles -> channel 0 shows 0xA5 one cycle after acceptance, channel 1 shows 0x3C one cycle later; in_ready stays 1 throughout.
- Back-pressure isolation:
  - Setup: out_ready=2'b10; send 0x11 sel=0, then 0x22 sel=0 -> the second beat stalls with in_ready=0.
  - Then present 0x33 sel=1 -> accepted immediately.
  - Release out_ready[0] -> 0x22 follows 0x11 on channel 0.
- Full throughput with simultaneous load and take: channel 1 full, out_ready[1]=1, stream 0x01..0x08 on sel=1 -> 8 beats in 8 consecutive cycles, in order, out_valid[1] never drops mid-stream.
- Illegal select, N_OUT=3: send 0xFF with sel=3 -> accepted, no out_valid set, sel_err pulses for exactly 1 cycle, drop_cnt=1. 300 such beats -> drop_cnt=255.
- Reset mid-operation: both channels full with out_ready=0, assert rst for 1 cycle -> out_valid=0 next cycle, drop_cnt=0, and no stale beat appears afterwards.
